iorq_cycle_fsm: RTL and testbench
=================================

# iorq_cycle_fsm

Multi-channel, parametrised I/O-cycle tick generator for the Z8S180 running in IOC=1 mode. It decodes a block of `NUM_CH` consecutive I/O port addresses and counts falling `phi` edges within each IORQ read or write cycle. For the selected channel it emits one-edge capture windows: `rd_tick` on falling edge `RD_EDGE` and `wr_tick` on falling edge `WR_EDGE`. It sits between the CPU bus pins and the peripheral registers (UART, SPI, LED and similar ports), and replaces the per-port single-purpose read-tick FSMs.

## Interface
Parameters:
- `ADDR_W`, 8: width of the decoded I/O address.
- `NUM_CH`, 4: number of consecutive ports (channels); 1..16.
- `BASE_ADDR`, 8'h40: port address of channel 0; channel i is `BASE_ADDR+i`.
- `RD_EDGE`, 0: falling-edge index at which read data is captured.
- `WR_EDGE`, 1: falling-edge index at which write data is captured.
- `CNT_W`, 3: edge-counter width; `RD_EDGE`, `WR_EDGE` < 2^CNT_W-1.

Ports:
- `phi` input 1: CPU phi clock. All state updates on the falling edge.
- `reset` input 1: synchronous, active-high, sampled on falling `phi`.
- `iorq` input 1: positive-logic IORQ.
- `rd` input 1: positive-logic RD.
- `wr` input 1: positive-logic WR.
- `m1` input 1: positive-logic M1. `iorq && m1` marks an interrupt acknowledge.
- `addr` input ADDR_W: CPU address, low bits.
- `rd_tick` output NUM_CH: one-hot read capture window, combinational.
- `wr_tick` output NUM_CH: one-hot write capture window, combinational.
- `sel` output NUM_CH: registered one-hot channel of the current cycle.
- `busy` output 1: registered; an I/O cycle for this block is in progress.
- `edge_cnt` output CNT_W: registered count of falling edges in the current cycle.
- `short_cycle` output 1: registered one-`phi` pulse when a cycle ends before its tick.
- `fault` output 1: registered one-`phi` pulse when `rd && wr` occur together during an I/O cycle.

## Operation
- Definitions:
  - `io_act = iorq && !m1 && (rd || wr)`.
  - `hit` = live one-hot decode of `addr` against `BASE_ADDR..BASE_ADDR+NUM_CH-1`. Addresses outside the range give all zeros.
- States, held in a 2-bit register:
  - IDLE: no cycle in progress.
  - RD: read cycle in progress.
  - WR: write cycle in progress.
  - HOLD: cycle ignored; wait for `iorq` to drop.
- IDLE transitions:
  - to RD when `io_act && rd && !wr && |hit`
  - to WR when `io_act && wr && !rd && |hit`
  - to HOLD when `io_act && rd && wr`
  - stay in IDLE otherwise, including any cycle outside the address range.
- On leaving IDLE for RD or WR: latch `hit` into `sel`, set `edge_cnt=1`, set `busy=1`.
- RD/WR:
  - `edge_cnt` increments on each falling edge while `io_act` holds, and saturates at all-ones (no wrap, so no second tick).
  - When `io_act` drops, return to IDLE and clear `sel`, `edge_cnt` and `busy`.
- RD/WR with `rd && wr` both true: go to HOLD, pulse `fault`, suppress ticks.
- HOLD: return to IDLE on the first falling edge with `!iorq`.
- Tick equations:
  - `rd_tick[i]` = `io_act && rd && !wr && cnt_eff==RD_EDGE && ch_eff[i]`.
  - `wr_tick` uses the same equation with `wr` and `WR_EDGE`.
  - In IDLE, `cnt_eff=0` and `ch_eff=hit`. In RD/WR, `cnt_eff=edge_cnt` and `ch_eff=sel`. In HOLD, ticks are 0.
  - Only RD state (or IDLE) may produce `rd_tick`; only WR state (or IDLE) may produce `wr_tick`.
- `short_cycle`: pulses for one `phi` cycle on the return to IDLE from RD when `edge_cnt <= RD_EDGE`, or from WR when `edge_cnt <= WR_EDGE`. In either case the tick's capture edge was never reached.
- Interrupt acknowledge (`m1` high) is never decoded.
- Reset mid-cycle:
  - State goes to IDLE and all registered outputs to 0.
  - If `io_act` is still true on the first falling edge after reset, a new cycle starts from IDLE using the live `hit`.

## Timing
- Reset values: `sel=0`, `busy=0`, `edge_cnt=0`, `short_cycle=0`, `fault=0`. Ticks are then 0 unless `io_act` is asserted.
- A tick is true for exactly one `phi` low-to-low interval. The consumer captures on the falling edge that ends that interval.
- Default parameters:
  - Read: data is captured on the first falling edge after IORQ&&RD assert (latency 0 edges).
  - Write: data is captured on the second falling edge (latency 1 edge).
- The decode on the first edge uses live `addr`, which must meet setup to falling `phi`. Later edges use the latched `sel`, so `addr` changes mid-cycle are ignored.
- Exactly one tick per cycle, at most one channel bit set.

## Structure
- `iorq_pkg`: state encoding constants (IDLE=0, RD=1, WR=2, HOLD=3) and the default port base constant.
- Sub-module `iorq_addr_decode`: parametrised range-to-one-hot decoder (`ADDR_W`, `NUM_CH`, `BASE_ADDR`). The top-level holds the FSM, counter and tick logic.

## Test plan
- Default parameters, read at 8'h42 held for 3 edges: `rd_tick=4'b0100` during the interval ending at edge 1 only; `wr_tick=0`; `edge_cnt` reads 1,2,3; `short_cycle=0`.
- Write at 8'h40 held for 3 edges: `wr_tick=4'b0001` only in the interval ending at edge 2; `sel=4'b0001`.
- Write at 8'h41 dropped after 1 edge: no `wr_tick`; `short_cycle` pulses once; `busy` returns to 0.
- Out-of-range read (8'h44, 8'h3F), and `iorq&&m1&&rd`: all ticks 0, `busy=0`.
- `rd&&wr` asserted together at 8'h40: `fault` pulses; no ticks until `iorq` drops; the next normal read ticks correctly.
- Reset asserted at edge 2 of a long write: outputs cleared on that edge; a read at 8'h43 started after reset ticks `4'b1000`. Repeat with `RD_EDGE=2`, `CNT_W=2` and a long read: only one tick, because the counter saturates at 3 and does not wrap.

Source files
------------

// File: rtl/iorq_pkg.sv
// rtl/iorq_pkg.sv - shared state encoding and default port base for the I/O cycle tick generator
package iorq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_HOLD = 2'd3
    } iorq_state_e;

    localparam int unsigned DEF_BASE_ADDR = 32'h40;

endpackage

// File: rtl/iorq_cycle_fsm_if.sv
// rtl/iorq_cycle_fsm_if.sv - CPU I/O bus pins and per-channel capture outputs
interface iorq_cycle_fsm_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 3
);
    logic              iorq;
    logic              rd;
    logic              wr;
    logic              m1;
    logic [ADDR_W-1:0] addr;
    logic [NUM_CH-1:0] rd_tick;
    logic [NUM_CH-1:0] wr_tick;
    logic [NUM_CH-1:0] sel;
    logic              busy;
    logic [CNT_W-1:0]  edge_cnt;
    logic              short_cycle;
    logic              fault;

    modport master (
        output iorq, rd, wr, m1, addr,
        input  rd_tick, wr_tick, sel, busy, edge_cnt, short_cycle, fault
    );

    modport slave (
        input  iorq, rd, wr, m1, addr,
        output rd_tick, wr_tick, sel, busy, edge_cnt, short_cycle, fault
    );
endinterface

// File: rtl/iorq_addr_decode.sv
// rtl/iorq_addr_decode.sv - range-to-one-hot decode of a block of consecutive I/O ports
module iorq_addr_decode
    import iorq_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NUM_CH-1:0] hit_o
);

    // Compare at 32 bits so a block near the top of the space never aliases to low ports.
    always_comb begin
        hit_o = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            hit_o[i] = (32'(addr_i) == (BASE_ADDR + i));
        end
    end

endmodule

// File: rtl/iorq_cycle_fsm.sv
// rtl/iorq_cycle_fsm.sv - per-channel read/write capture tick generator for IORQ cycles,
// all state advancing on falling phi
module iorq_cycle_fsm
    import iorq_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned RD_EDGE   = 0,
    parameter int unsigned WR_EDGE   = 1,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             phi,
    input  logic             reset,
    iorq_cycle_fsm_if.slave  bus
);

    localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_EDGE);
    localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WR_EDGE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    iorq_state_e       state_q, state_d;
    logic [NUM_CH-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              short_q, short_d;
    logic              fault_q, fault_d;

    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] ch_eff;
    logic [CNT_W-1:0]  cnt_eff;
    logic              io_act, rd_only, wr_only;

    iorq_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_CH    (NUM_CH),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .addr_i (bus.addr),
        .hit_o  (hit)
    );

    assign io_act  = bus.iorq && !bus.m1 && (bus.rd || bus.wr);
    assign rd_only = io_act && bus.rd && !bus.wr;
    assign wr_only = io_act && bus.wr && !bus.rd;

    always_ff @(negedge phi) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            short_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            short_q <= short_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        short_d = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((rd_only || wr_only) && (|hit)) begin
                    state_d = rd_only ? ST_RD : ST_WR;
                    sel_d   = hit;
                    cnt_d   = CNT_ONE;
                    busy_d  = 1'b1;
                end else if (io_act && bus.rd && bus.wr) begin
                    state_d = ST_HOLD;
                    fault_d = 1'b1;
                end
            end
            ST_RD, ST_WR: begin
                if (!io_act || (bus.rd && bus.wr)) begin
                    state_d = io_act ? ST_HOLD : ST_IDLE;
                    fault_d = io_act;
                    sel_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    // The capture edge was never reached if the count never got past it.
                    short_d = !io_act && ((state_q == ST_RD) ? (cnt_q <= RD_CNT) : (cnt_q <= WR_CNT));
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!bus.iorq) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_eff     = cnt_q;
        ch_eff      = sel_q;
        bus.rd_tick = '0;
        bus.wr_tick = '0;
        if (state_q == ST_IDLE) begin
            cnt_eff = '0;
            ch_eff  = hit;
        end
        if (rd_only && (cnt_eff == RD_CNT) && (state_q == ST_IDLE || state_q == ST_RD))
            bus.rd_tick = ch_eff;
        if (wr_only && (cnt_eff == WR_CNT) && (state_q == ST_IDLE || state_q == ST_WR))
            bus.wr_tick = ch_eff;
    end

    assign bus.sel         = sel_q;
    assign bus.busy        = busy_q;
    assign bus.edge_cnt    = cnt_q;
    assign bus.short_cycle = short_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_iorq_cycle_fsm.sv
// tb/tb_iorq_cycle_fsm.sv - directed scoreboard bench for iorq_cycle_fsm, default and saturating-counter configurations
module tb_iorq_cycle_fsm;

    typedef struct packed {
        logic [3:0] rt;
        logic [3:0] wt;
        logic [3:0] sel;
        logic       busy;
        logic [2:0] cnt;
        logic       sc;
        logic       flt;
    } obs_t;

    logic phi   = 1'b1;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];

    iorq_cycle_fsm_if #(.ADDR_W(8), .NUM_CH(4), .CNT_W(3)) bus_a ();
    iorq_cycle_fsm_if #(.ADDR_W(8), .NUM_CH(4), .CNT_W(2)) bus_b ();

    iorq_cycle_fsm #(
        .ADDR_W(8), .NUM_CH(4), .BASE_ADDR(32'h40), .RD_EDGE(0), .WR_EDGE(1), .CNT_W(3)
    ) u_dut_a (
        .phi   (phi),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    iorq_cycle_fsm #(
        .ADDR_W(8), .NUM_CH(4), .BASE_ADDR(32'h40), .RD_EDGE(2), .WR_EDGE(1), .CNT_W(2)
    ) u_dut_b (
        .phi   (phi),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    always #5 phi = ~phi;

    function automatic obs_t mk(input logic [3:0] rt, input logic [3:0] wt, input logic [3:0] sel,
                                input logic busy, input logic [2:0] cnt, input logic sc, input logic flt);
        obs_t o;
        o.rt = rt; o.wt = wt; o.sel = sel; o.busy = busy; o.cnt = cnt; o.sc = sc; o.flt = flt;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One phi low-to-low interval: drive after the falling edge, sample mid-interval.
    task automatic step(input int d, input string tag, input logic rst, input logic io, input logic r,
                        input logic w, input logic m, input logic [7:0] a, input obs_t e);
        obs_t got;
        obs_t ex;
        @(negedge phi);
        #1;
        reset = rst;
        if (d == 0) begin
            bus_a.iorq = io; bus_a.rd = r; bus_a.wr = w; bus_a.m1 = m; bus_a.addr = a;
        end else begin
            bus_b.iorq = io; bus_b.rd = r; bus_b.wr = w; bus_b.m1 = m; bus_b.addr = a;
        end
        exp_q.push_back(e);
        @(posedge phi);
        if (d == 0)
            got = {bus_a.rd_tick, bus_a.wr_tick, bus_a.sel, bus_a.busy, bus_a.edge_cnt,
                   bus_a.short_cycle, bus_a.fault};
        else
            got = {bus_b.rd_tick, bus_b.wr_tick, bus_b.sel, bus_b.busy, 1'b0, bus_b.edge_cnt,
                   bus_b.short_cycle, bus_b.fault};
        ex = exp_q.pop_front();
        chk({tag, " rd_tick"},     {4'd0, got.rt},   {4'd0, ex.rt});
        chk({tag, " wr_tick"},     {4'd0, got.wt},   {4'd0, ex.wt});
        chk({tag, " sel"},         {4'd0, got.sel},  {4'd0, ex.sel});
        chk({tag, " busy"},        {7'd0, got.busy}, {7'd0, ex.busy});
        chk({tag, " edge_cnt"},    {5'd0, got.cnt},  {5'd0, ex.cnt});
        chk({tag, " short_cycle"}, {7'd0, got.sc},   {7'd0, ex.sc});
        chk({tag, " fault"},       {7'd0, got.flt},  {7'd0, ex.flt});
    endtask

    initial begin
        bus_a.iorq = 0; bus_a.rd = 0; bus_a.wr = 0; bus_a.m1 = 0; bus_a.addr = 8'h00;
        bus_b.iorq = 0; bus_b.rd = 0; bus_b.wr = 0; bus_b.m1 = 0; bus_b.addr = 8'h00;

        step(0, "reset0", 1, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "reset1", 0, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));

        // read at 0x42 held for three edges
        step(0, "rd42_e1",   0, 1,1,0,0, 8'h42, mk(4'b0100, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "rd42_e2",   0, 1,1,0,0, 8'h42, mk(4'b0000, 4'b0000, 4'b0100, 1, 3'd1, 0, 0));
        step(0, "rd42_e3",   0, 1,1,0,0, 8'h42, mk(4'b0000, 4'b0000, 4'b0100, 1, 3'd2, 0, 0));
        step(0, "rd42_drop", 0, 0,0,0,0, 8'h42, mk(4'b0000, 4'b0000, 4'b0100, 1, 3'd3, 0, 0));
        step(0, "rd42_idle", 0, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));

        // write at 0x40 held for three edges
        step(0, "wr40_e1",   0, 1,0,1,0, 8'h40, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "wr40_e2",   0, 1,0,1,0, 8'h40, mk(4'b0000, 4'b0001, 4'b0001, 1, 3'd1, 0, 0));
        step(0, "wr40_e3",   0, 1,0,1,0, 8'h40, mk(4'b0000, 4'b0000, 4'b0001, 1, 3'd2, 0, 0));
        step(0, "wr40_drop", 0, 0,0,0,0, 8'h40, mk(4'b0000, 4'b0000, 4'b0001, 1, 3'd3, 0, 0));
        step(0, "wr40_idle", 0, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));

        // short write at 0x41
        step(0, "wr41_e1",    0, 1,0,1,0, 8'h41, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "wr41_drop",  0, 0,0,0,0, 8'h41, mk(4'b0000, 4'b0000, 4'b0010, 1, 3'd1, 0, 0));
        step(0, "wr41_short", 0, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 1, 0));
        step(0, "wr41_idle",  0, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));

        // out of range and interrupt acknowledge
        step(0, "oor44_a",  0, 1,1,0,0, 8'h44, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "oor44_b",  0, 1,1,0,0, 8'h44, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "oor3f",    0, 1,1,0,0, 8'h3F, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "inta_a",   0, 1,1,0,1, 8'h40, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "inta_b",   0, 1,1,0,1, 8'h40, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "oor_idle", 0, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));

        // rd and wr together, then a clean read
        step(0, "both_e1",   0, 1,1,1,0, 8'h40, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "both_flt",  0, 1,1,1,0, 8'h40, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 1));
        step(0, "both_hold", 0, 1,1,0,0, 8'h40, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "both_drop", 0, 0,0,0,0, 8'h40, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "rd40_e1",   0, 1,1,0,0, 8'h40, mk(4'b0001, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "rd40_drop", 0, 0,0,0,0, 8'h40, mk(4'b0000, 4'b0000, 4'b0001, 1, 3'd1, 0, 0));
        step(0, "rd40_idle", 0, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));

        // reset in the middle of a write, restart, then read at 0x43
        step(0, "rstwr_e1",   0, 1,0,1,0, 8'h42, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "rstwr_rst",  1, 1,0,1,0, 8'h42, mk(4'b0000, 4'b0100, 4'b0100, 1, 3'd1, 0, 0));
        step(0, "rstwr_clr",  0, 1,0,1,0, 8'h42, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(0, "rstwr_new",  0, 0,0,0,0, 8'h42, mk(4'b0000, 4'b0000, 4'b0100, 1, 3'd1, 0, 0));
        step(0, "rd43_e1",    0, 1,1,0,0, 8'h43, mk(4'b1000, 4'b0000, 4'b0000, 0, 3'd0, 1, 0));
        step(0, "rd43_drop",  0, 0,0,0,0, 8'h43, mk(4'b0000, 4'b0000, 4'b1000, 1, 3'd1, 0, 0));
        step(0, "rd43_idle",  0, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));

        // RD_EDGE=2, CNT_W=2: long read saturates at 3 and never ticks twice
        step(1, "b_rd_e1",   0, 1,1,0,0, 8'h41, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(1, "b_rd_e2",   0, 1,1,0,0, 8'h41, mk(4'b0000, 4'b0000, 4'b0010, 1, 3'd1, 0, 0));
        step(1, "b_rd_e3",   0, 1,1,0,0, 8'h41, mk(4'b0010, 4'b0000, 4'b0010, 1, 3'd2, 0, 0));
        for (int k = 4; k <= 8; k++)
            step(1, $sformatf("b_rd_e%0d", k), 0, 1,1,0,0, 8'h41, mk(4'b0000, 4'b0000, 4'b0010, 1, 3'd3, 0, 0));
        step(1, "b_rd_drop", 0, 0,0,0,0, 8'h41, mk(4'b0000, 4'b0000, 4'b0010, 1, 3'd3, 0, 0));
        step(1, "b_rd_idle", 0, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));

        // RD_EDGE=2: read dropped before the capture edge is short
        step(1, "b_sh_e1",    0, 1,1,0,0, 8'h40, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));
        step(1, "b_sh_e2",    0, 1,1,0,0, 8'h40, mk(4'b0000, 4'b0000, 4'b0001, 1, 3'd1, 0, 0));
        step(1, "b_sh_drop",  0, 0,0,0,0, 8'h40, mk(4'b0000, 4'b0000, 4'b0001, 1, 3'd2, 0, 0));
        step(1, "b_sh_short", 0, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 1, 0));
        step(1, "b_sh_idle",  0, 0,0,0,0, 8'h00, mk(4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
